exec_muldiv_unit: RTL
=====================

Name: exec_muldiv_unit

Overview:
- Iterative multiply/divide unit sitting beside the execute-stage ALU.
- Supports signed/unsigned multiply and divide of WIDTH-bit operands, plus direct HI/LO writes.
- Holds the architectural HI/LO registers and raises busy so the hazard unit stalls the pipeline.
- Honours the pipeline flush used by the execute latch.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be ≥4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- nRST  input  1  asynchronous, active-low reset.
- start  input  1  request valid this cycle, qualified by op.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
- opA  input  WIDTH  rs operand (multiplicand/dividend/MTxx data).
- opB  input  WIDTH  rt operand (multiplier/divisor).
- flush  input  1  squash in-flight operation.
- busy  output  1  operation in progress; hazard unit stalls on MFHI/MFLO/new muldiv.
- done  output  1  one-cycle pulse in the cycle HI/LO are written by MULT/DIV.
- hi  output  WIDTH  HI register (MFHI source).
- lo  output  WIDTH  LO register (MFLO source).

Behaviour:
- Reset (nRST low, any time including mid-operation): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal datapath regs=0. Takes effect immediately.
- States: IDLE, RUN, FIX.
- IDLE:
  - start with op 0-3 and flush=0: latch operands, go to RUN, counter=WIDTH.
  - For signed ops, store operand magnitudes and result/remainder sign flags.
- RUN:
  - One iteration per cycle, exactly WIDTH iterations; counter decrements; when counter reaches 1 go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, WIDTH+1-bit partial remainder.
- FIX:
  - Apply sign correction; write hi/lo at the closing edge; assert done for this cycle only; return to IDLE.
- Latency: start at cycle 0 → done in cycle WIDTH+1 → new hi/lo visible cycle WIDTH+2.
- busy = (state != IDLE); combinational from state, high cycles 1..WIDTH+1.
- Multiply result: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2*WIDTH product.
  - Signed: product negated (two's complement, 2*WIDTH) when operand signs differ.
- Divide result: lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (no trap): lo = all ones, hi = opA, for both signed and unsigned. Latency unchanged.
- Signed overflow (most-negative / -1): lo = most-negative value, hi = 0. Falls out of magnitude arithmetic; must not be special-cased incorrectly.
- MTHI/MTLO in IDLE with flush=0: write hi (or lo) = opA at that edge. busy stays 0, no done.
- No-op codes 6-7: no state change.
- start while busy: ignored, no effect on the running operation.
- flush in RUN or FIX: next state IDLE, hi/lo unchanged, done=0 (flush in FIX suppresses the write). A start in the following cycle is accepted normally.
- flush and start in the same IDLE cycle: flush wins; request dropped, MTHI/MTLO not written.
- Operand inputs may change after start; the unit uses only the latched copies.

Test Plan (WIDTH=32):
- MULTU opA=0xFFFFFFFF, opB=0xFFFFFFFF → busy high 33 cycles, done in cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT opA=0xFFFFFFFD (-3), opB=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MTLO opA=0x1234 → lo=0x00001234 next cycle, busy never asserted.
- DIV opA=0xFFFFFFF9 (-7), opB=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU opA=7, opB=0 → lo=0xFFFFFFFF, hi=0x00000007.
- DIV opA=0x80000000, opB=0xFFFFFFFF → lo=0x80000000, hi=0x00000000, no X, normal latency.
- Preload hi=0xAAAA, lo=0x5555. Start MULTU 3*5, flush in cycle 10 → busy low from cycle 11, done never pulses, hi/lo unchanged. Start DIVU 9/2 at cycle 11 → lo=4, hi=1 at cycle 44.
- Start DIV, drop nRST in cycle 15 → hi=lo=0, busy=0, done=0 immediately. Start (issued while nRST low) ignored. After release, MULTU 2*3 → lo=6, hi=0.

Source files
------------

// File: rtl/exec_muldiv_unit.sv
// Iterative multiply/divide unit beside the execute-stage ALU.
// Owns the architectural HI/LO registers and holds busy while an operation runs.
module exec_muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [2:0] OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_q;
  logic               is_div, neg_res, neg_rem, div0;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Signed ops work on magnitudes; sign flags restore the result in FIX.
  logic             sgn_op, sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign sgn_op = ~op[0];
  assign sa     = sgn_op & opA[WIDTH-1];
  assign sb     = sgn_op & opB[WIDTH-1];
  assign a_mag  = neg_w(opA, sa);
  assign b_mag  = neg_w(opB, sb);

  // Multiply: acc = {partial sum, multiplier}. Divide: acc = {remainder, dividend/quotient}.
  logic [WIDTH:0]     mul_sum, rem_sh, div_trial;
  logic [2*WIDTH-1:0] acc_nxt;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
  assign rem_sh    = acc[2*WIDTH-1:WIDTH-1];
  assign div_trial = rem_sh - {1'b0, b_q};

  always_comb begin
    acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!div_trial[WIDTH])
        acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, hi_res, lo_res;

  assign prod   = neg_2w(acc, neg_res);
  assign quo    = div0 ? '1 : neg_w(acc[WIDTH-1:0], neg_res);
  assign rem    = neg_w(acc[2*WIDTH-1:WIDTH], neg_rem);
  assign hi_res = is_div ? rem : prod[2*WIDTH-1:WIDTH];
  assign lo_res = is_div ? quo : prod[WIDTH-1:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      b_q     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            if (op <= OP_DIVU) begin
              state   <= RUN;
              cnt     <= CNT_INIT;
              is_div  <= op[1];
              neg_res <= sa ^ sb;
              neg_rem <= sa;
              div0    <= (opB == '0);
              acc     <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
              b_q     <= op[1] ? b_mag : a_mag;
            end else if (op == OP_MTHI) begin
              hi <= opA;
            end else if (op == OP_MTLO) begin
              lo <= opA;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE)
              state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            hi <= hi_res;
            lo <= lo_res;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FIX) && !flush;

endmodule
